fetch_unit: RTL and testbench

Instruction fetch stage, placed directly upstream of decode.
- Owns the PC and issues in-order word requests to instruction memory.
- Buffers returned instructions in a 2-entry queue and presents {inst, pc} to decode with a valid/ready handshake.
- On a redirect (branch/jump) it flushes buffered and in-flight instructions.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, canonical NOP, reset vector
// and the fetch-to-decode bundle.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  // Presented to decode whenever nothing valid is buffered.
  localparam fetch_pkt_t NOP_PKT = '{inst: NOP_INST, pc: '0};

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {inst, pc} packets; flush wins over
// push/pop and the head reads as a NOP packet while empty.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_pkt_t    push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_pkt_t    head,
  output logic [CW-1:0] count
);

  fetch_pkt_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & (count != '0) & ~flush;

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // count/pointers alone, so the entries can map onto plain registers or RAM.
  // NOTE: sequential state always uses non-blocking assignment so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : NOP_PKT;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word requests under a
// credit limit, buffers responses and hands {inst, pc} to decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] redirect_aligned;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding_after_rsp;
  logic [CW:0]     in_use;
  logic            fire;
  logic            rsp_counted;
  logic            push;
  logic            pop;
  fetch_pkt_t      push_data;
  fetch_pkt_t      head;

  assign redirect_aligned = redirect_pc & ~32'h3;

  // Buffered words still hold a credit, so the queue can never overflow.
  assign in_use    = {1'b0, outstanding} + {1'b0, count};
  assign imem_req  = ~rst & ~redirect_valid & (in_use < CREDITS);
  assign imem_addr = pc;
  assign fire      = imem_req & imem_gnt;

  // A response with nothing outstanding (stray after reset) is not counted.
  assign rsp_counted           = imem_rvalid & (outstanding != '0);
  assign outstanding_after_rsp = outstanding - CW'(rsp_counted);

  assign push      = imem_rvalid & ~redirect_valid & (discard == '0);
  assign pop       = inst_valid & inst_ready;
  assign push_data = '{inst: imem_rdata, pc: resp_pc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old path and must be dropped.
      pc          <= redirect_aligned;
      resp_pc     <= redirect_aligned;
      outstanding <= outstanding_after_rsp;
      discard     <= outstanding_after_rsp;
    end else begin
      if (fire) pc <= pc + 32'd4;
      if (push) resp_pc <= resp_pc + 32'd4;
      outstanding <= outstanding_after_rsp + CW'(fire);
      if (imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  assign inst_valid = (count != '0);
  assign inst_out   = head.inst;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// corner sequences and a randomized run against a stream-level model.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: every word is a fixed function of its address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Behavioural instruction memory: in-order responses after a latency.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];
  int    cyc      = 0;
  int    lat_min  = 0;
  int    lat_rand = 0;

  // Stream model: decode must see consecutive PCs from the last restart
  // point, and memory must see consecutive fetch addresses from it.
  logic [31:0] exp_out_pc = RST_PC;
  logic [31:0] exp_fetch  = RST_PC;
  logic        prev_wait  = 1'b0;
  logic [31:0] prev_addr  = 32'h0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_pc    = 32'h0;
  logic [31:0] prev_inst  = 32'h0;
  logic        prev_redir = 1'b0;
  int          handshakes = 0;

  logic        s_req;
  logic        s_iv;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_inst;

  task automatic tick(input logic gnt, input logic ready, input logic redir, input logic [31:0] rpc);
    logic rv;
    @(negedge clk);
    rv = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_gnt       = gnt;
    inst_ready     = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rvalid    = rv;
    imem_rdata     = rv ? memw(pend[0].addr) : 32'hDEAD_BEEF;
    #1;
    s_req  = imem_req;
    s_iv   = inst_valid;
    s_addr = imem_addr;
    s_pc   = inst_pc;
    s_inst = inst_out;
    if (redir) check("req_in_redirect", 32'(s_req), 32'd0);
    if (prev_redir) check("flush_valid", 32'(s_iv), 32'd0);
    if (prev_wait && !redir) begin
      check("req_held", 32'(s_req), 32'd1);
      check("addr_held", s_addr, prev_addr);
    end
    if (prev_stall) begin
      check("valid_held", 32'(s_iv), 32'd1);
      check("pc_held", s_pc, prev_pc);
      check("inst_held", s_inst, prev_inst);
    end
    if (s_iv && ready) begin
      check("deliver_pc", s_pc, exp_out_pc);
      check("deliver_inst", s_inst, memw(exp_out_pc));
      exp_out_pc = exp_out_pc + 32'd4;
      handshakes++;
    end
    if (s_req && gnt) begin
      check("fetch_addr", s_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      pend.push_back('{addr: s_addr, due: cyc + 1 + lat_min + int'($urandom_range(lat_rand, 0))});
    end
    if (rv) void'(pend.pop_front());
    if (redir) begin
      exp_out_pc = rpc & ~32'h3;
      exp_fetch  = rpc & ~32'h3;
    end
    prev_wait  = s_req && !gnt && !redir;
    prev_addr  = s_addr;
    prev_stall = s_iv && !ready && !redir;
    prev_pc    = s_pc;
    prev_inst  = s_inst;
    prev_redir = redir;
    cyc++;
  endtask

  // Asynchronous reset between clock edges; memory is reset with the core.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_inst_out", inst_out, NOP_INST);
    check("rst_inst_pc", inst_pc, 32'h0);
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    pend.delete();
    exp_out_pc = RST_PC;
    exp_fetch  = RST_PC;
    prev_wait  = 1'b0;
    prev_stall = 1'b0;
    prev_redir = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_valid(input string name, input logic ready);
    int k = 0;
    do begin
      tick(1'b1, ready, 1'b0, 32'h0);
      k++;
    end while (!s_iv && k < 40);
    check(name, 32'(s_iv), 32'd1);
  endtask

  typedef struct {
    logic        gnt;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t        tbl [14];
  logic [31:0] got [3];
  int          ng;
  logic        rd;
  logic [31:0] tgt;

  initial begin
    // Zero-wait memory from reset, then a 4-cycle grant stall on 0x8 and a
    // decode stall that fills the queue.
    tbl = '{
      '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00},
      '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00},
      '{1'b0, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00},
      '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04},
      '{1'b0, 1'b1, 1'b1, 32'h08, 1'b0, 32'h00},
      '{1'b0, 1'b1, 1'b1, 32'h08, 1'b0, 32'h00},
      '{1'b1, 1'b1, 1'b1, 32'h08, 1'b0, 32'h00},
      '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h00},
      '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h08},
      '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h08},
      '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08},
      '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C},
      '{1'b0, 1'b1, 1'b1, 32'h14, 1'b0, 32'h00},
      '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10}
    };

    apply_reset();
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].gnt, tbl[i].ready, 1'b0, 32'h0);
      check($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].e_req));
      check($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
      check($sformatf("tbl%0d_valid", i), 32'(s_iv), 32'(tbl[i].e_iv));
      if (tbl[i].e_iv) begin
        check($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
        check($sformatf("tbl%0d_inst", i), s_inst, memw(tbl[i].e_pc));
      end
    end

    // Decode stall: queue fills, request drops, head held; then drains in order.
    apply_reset();
    run_to_valid("stall_first_valid", 1'b0);
    check("stall_first_pc", s_pc, RST_PC);
    repeat (5) tick(1'b1, 1'b0, 1'b0, 32'h0);
    check("stall_req_off", 32'(s_req), 32'd0);
    check("stall_valid", 32'(s_iv), 32'd1);
    check("stall_pc_held", s_pc, RST_PC);
    got = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    ng  = 0;
    for (int k = 0; k < 20 && ng < 3; k++) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      if (s_iv) begin
        got[ng] = s_pc;
        ng++;
      end
    end
    check("drain_pc0", got[0], RST_PC);
    check("drain_pc1", got[1], RST_PC + 32'd4);
    check("drain_pc2", got[2], RST_PC + 32'd8);

    // Redirect to an unaligned target coincident with rvalid and a pop.
    apply_reset();
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    check("redir_pop_valid", 32'(s_iv), 32'd1);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_next_req", 32'(s_req), 32'd1);
    check("redir_next_addr", s_addr, 32'h0000_0200);
    check("redir_next_valid", 32'(s_iv), 32'd0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_t3_valid", 32'(s_iv), 32'd1);
    check("redir_t3_pc", s_pc, 32'h0000_0200);

    // Redirect with two requests outstanding on a slow memory.
    apply_reset();
    lat_min = 2;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    run_to_valid("stale_first_valid", 1'b1);
    check("stale_first_pc", s_pc, 32'h0000_0100);
    check("stale_first_inst", s_inst, memw(32'h0000_0100));
    run_to_valid("stale_second_valid", 1'b1);
    check("stale_second_pc", s_pc, 32'h0000_0104);

    // Asynchronous reset while the queue is full, then restart.
    repeat (10) tick(1'b1, 1'b0, 1'b0, 32'h0);
    check("pre_reset_valid", 32'(s_iv), 32'd1);
    apply_reset();
    lat_min = 0;
    run_to_valid("restart_valid", 1'b1);
    check("restart_pc", s_pc, RST_PC);

    // Randomized traffic against the stream model, including PC wrap.
    apply_reset();
    lat_rand   = 2;
    handshakes = 0;
    for (int i = 0; i < 4000; i++) begin
      rd  = ($urandom_range(99, 0) < 4);
      tgt = $urandom();
      if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFE0 | 32'($urandom_range(31, 0));
      if (i == 1500 || i == 3100) apply_reset();
      else tick($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 75, rd, tgt);
    end
    check("random_progress", 32'(handshakes > 300), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
